zvc_stream_controller: RTL

Sequences the 2-stage, non-stallable 128-lane zero-value compressor. It accepts lowered-IFM/mapping-table lines over a valid/ready handshake and tracks each issued line through the compressor's fixed latency. Results are captured in an output FIFO with a per-line nonzero count. Credit-based issue ensures no result is ever dropped, and a flush sequence drains the path.

---
 rtl/zvc_stream_controller_pkg.sv | 34 +++
 rtl/zvc_stream_controller_result_fifo.sv | 73 +++++++
 rtl/zvc_stream_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/zvc_stream_controller_pkg.sv
// Shared widths, FSM state type and the lane nonzero counter for the ZVC stream controller.
package zvc_stream_controller_pkg;

    localparam int unsigned WORD_WIDTH    = 8;
    localparam int unsigned DIST_WIDTH    = 7;
    localparam int unsigned MAX_LIFM_RSIZ = 4;
    localparam int unsigned PIPE_LAT      = 2;
    localparam int unsigned FIFO_DEPTH    = 4;

    localparam int unsigned LANES     = 128;
    localparam int unsigned LINE_W    = LANES * WORD_WIDTH;
    localparam int unsigned MT_LANE_W = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int unsigned MT_W      = LANES * MT_LANE_W;
    localparam int unsigned NNZ_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } zvc_state_e;

    // Number of lanes whose mapping-table field is nonzero (0..128 fits in NNZ_W).
    function automatic logic [NNZ_W-1:0] count_nnz(input logic [MT_W-1:0] mt);
        logic [NNZ_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mt[i*MT_LANE_W +: MT_LANE_W] != '0) begin
                n = n + NNZ_W'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/zvc_stream_controller_result_fifo.sv
// Synchronous result FIFO with same-cycle push/pop and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module zvc_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;
    logic             full;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign do_pop = pop && !empty;
    assign count  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Head is forced to zero when empty so outputs are clean out of reset.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Issue credit must keep the FIFO from ever being full when a result lands.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
        else $error("zvc_result_fifo: push while full");

endmodule

// File: rtl/zvc_stream_controller.sv
// Issue/credit sequencer for the fixed-latency 128-lane zero-value compressor:
// tracks lines through the compressor, buffers results, and drains on flush.
module zvc_stream_controller
    import zvc_stream_controller_pkg::*;
#(
    parameter int unsigned PIPE_LAT   = zvc_stream_controller_pkg::PIPE_LAT,
    parameter int unsigned FIFO_DEPTH = zvc_stream_controller_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LINE_W-1:0] in_lifm,
    input  logic [MT_W-1:0]   in_mt,
    output logic [LINE_W-1:0] cmp_lifm_line,
    output logic [MT_W-1:0]   cmp_mt_line,
    input  logic [LINE_W-1:0] cmp_lifm_comp,
    input  logic [MT_W-1:0]   cmp_mt_comp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LINE_W-1:0] out_lifm,
    output logic [MT_W-1:0]   out_mt,
    output logic [NNZ_W-1:0]  out_nnz,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              busy
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);
    localparam int unsigned ENT_W = LINE_W + MT_W + NNZ_W;

    zvc_state_e                     state_q, state_d;
    logic [PIPE_LAT-1:0]            vld_sr_q, vld_sr_d;
    logic [PIPE_LAT-1:0][NNZ_W-1:0] nnz_sr_q, nnz_sr_d;
    logic                           flush_done_q, flush_done_d;
    logic                           rdy_en_q, rdy_en_d;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [ENT_W-1:0] fifo_rd_data;
    logic [SUM_W-1:0] inflight;
    logic [SUM_W-1:0] occupancy;
    logic [NNZ_W-1:0] nnz_in;
    logic             credit_ok;
    logic             issue;
    logic             push;
    logic             pop;

    // Credit counts every line not yet popped: in the compressor plus in the FIFO.
    always_comb begin
        inflight = '0;
        for (int unsigned k = 0; k < PIPE_LAT; k++) begin
            inflight = inflight + SUM_W'(vld_sr_q[k]);
        end
    end

    assign occupancy = SUM_W'(fifo_count) + inflight;
    assign credit_ok = (occupancy < SUM_W'(FIFO_DEPTH));
    assign busy      = (vld_sr_q != '0) || (fifo_count != '0);
    assign in_ready  = rdy_en_q && (state_q != DRAIN) && !flush_req && credit_ok;
    assign issue     = in_valid && in_ready;
    assign nnz_in    = count_nnz(in_mt);

    assign cmp_lifm_line = issue ? in_lifm : '0;
    assign cmp_mt_line   = issue ? in_mt   : '0;

    always_comb begin
        vld_sr_d    = vld_sr_q;
        nnz_sr_d    = nnz_sr_q;
        vld_sr_d[0] = issue;
        nnz_sr_d[0] = issue ? nnz_in : '0;
        for (int unsigned k = 1; k < PIPE_LAT; k++) begin
            vld_sr_d[k] = vld_sr_q[k-1];
            nnz_sr_d[k] = nnz_sr_q[k-1];
        end
    end

    assign rdy_en_d = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr_q <= '0;
            nnz_sr_q <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            vld_sr_q <= vld_sr_d;
            nnz_sr_q <= nnz_sr_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    assign push = vld_sr_q[PIPE_LAT-1];
    assign pop  = out_valid && out_ready;

    zvc_result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push    (push),
        .wr_data ({cmp_lifm_comp, cmp_mt_comp, nnz_sr_q[PIPE_LAT-1]}),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid                   = !fifo_empty;
    assign {out_lifm, out_mt, out_nnz} = fifo_rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_d = DRAIN;
                end else if (!busy && !issue) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A held flush_req must not re-trigger during the cycle its done pulse is visible.
    always_comb begin
        flush_done_d = 1'b0;
        case (state_q)
            IDLE:    flush_done_d = flush_req && !busy && !flush_done_q;
            DRAIN:   flush_done_d = !busy;
            default: flush_done_d = 1'b0;
        endcase
    end

    assign flush_done = flush_done_q;

endmodule
